// File: rtl/dcache_arb.sv
// dcache_arb: arbitrates two requesters onto a single dcache port and keeps
// exactly one transaction outstanding (IDLE -> REQ -> [RESP] -> IDLE).
// Build option: define DCACHE_ARB_RR_EN to break ties round-robin; without it
// requester 0 always beats requester 1.
// MAX_WAIT must be at least 1.

module dcache_arb #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_wstrb,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_ack,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        dc_valid,
  output logic        dc_op,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_wstrb,
  output logic [31:0] dc_wdata,
  input  logic        dc_ready,
  input  logic        dc_rvalid,
  input  logic [31:0] dc_rdata,
  output logic        dbg_timeout
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_dc_valid;
  logic [1:0]    r_req_ack;
  logic [1:0]    r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_op;
  logic [31:0]   r_addr;
  logic [3:0]    r_wstrb;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_wait_cnt;
  logic          r_timeout;
  // Last requester granted; while a transaction is outstanding it is also its owner.
  logic          r_last_grant;

  logic          w_any_req;
  logic          w_winner;

  // Pick the requester that would be granted if the FSM were idle this cycle.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    w_any_req = |req_valid;
`ifdef DCACHE_ARB_RR_EN
    if (req_valid == 2'b11) begin
      w_winner = ~r_last_grant;
    end else begin
      w_winner = ~req_valid[0];
    end
`else
    w_winner = ~req_valid[0];
`endif
  end

  // Transaction FSM with registered handshake outputs, payload latch and wait counter.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_dc_valid   <= 1'b0;
      r_req_ack    <= 2'b00;
      r_rsp_valid  <= 2'b00;
      r_rsp_rdata  <= 32'h0;
      r_op         <= 1'b0;
      r_addr       <= 32'h0;
      r_wstrb      <= 4'h0;
      r_wdata      <= 32'h0;
      r_wait_cnt   <= '0;
      r_timeout    <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_req_ack   <= 2'b00;
      r_rsp_valid <= 2'b00;

      // Count every cycle spent outstanding; saturate and latch the timeout flag.
      if (r_state != S_IDLE && r_wait_cnt != CNT_MAX) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
        if (r_wait_cnt == CNT_LAST) begin
          r_timeout <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_op         <= req_op[w_winner];
            r_addr       <= w_winner ? req_addr[63:32]  : req_addr[31:0];
            r_wstrb      <= w_winner ? req_wstrb[7:4]   : req_wstrb[3:0];
            r_wdata      <= w_winner ? req_wdata[63:32] : req_wdata[31:0];
            r_req_ack    <= {w_winner, ~w_winner};
            r_last_grant <= w_winner;
            r_wait_cnt   <= '0;
            r_dc_valid   <= 1'b1;
            r_state      <= S_REQ;
          end
        end

        S_REQ: begin
          if (dc_ready) begin
            r_dc_valid <= 1'b0;
            if (r_op || dc_rvalid) begin
              // Writes, and reads whose data returns with the accept, finish here.
              r_rsp_valid <= {r_last_grant, ~r_last_grant};
              if (!r_op) begin
                r_rsp_rdata <= dc_rdata;
              end
              r_state <= S_IDLE;
            end else begin
              r_state <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (dc_rvalid) begin
            r_rsp_valid <= {r_last_grant, ~r_last_grant};
            r_rsp_rdata <= dc_rdata;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_dc_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ack     = r_req_ack;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign dc_valid    = r_dc_valid;
  assign dc_op       = r_op;
  assign dc_addr     = r_addr;
  assign dc_wstrb    = r_wstrb;
  assign dc_wdata    = r_wdata;
  assign dbg_timeout = r_timeout;

endmodule
